// File: rtl/kbd_seg_ctrl.sv
// kbd_seg_ctrl: pops PS/2 scancode bytes from the receive FIFO, tracks
// make/break/extended prefixes, keeps the held key and a BCD press counter,
// and drives four active-low seven-segment digits.
//
// FIFO handshake: the FIFO presents its head byte on `data` while `ready`=1.
// The controller samples `ready`/`data` only while waiting. When it accepts
// a byte it drives `nextdata_n` low for exactly one cycle, which pops the
// FIFO. `ready` is not looked at again for two more cycles, so the FIFO has
// time to present its next head.
module kbd_seg_ctrl (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] data,
  input  logic       ready,
  output logic       nextdata_n,
  output logic       key_down,
  output logic [7:0] cur_code,
  output logic [7:0] press_cnt,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3
);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    POP  = 2'd1,
    PROC = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] byte_r;
  logic [7:0] byte_nx;
  logic       brk;
  logic       brk_nx;
  logic       key_down_nx;
  logic [7:0] cur_code_nx;
  logic [7:0] press_cnt_nx;
  logic       nextdata_n_nx;

  // Active-high segment pattern for a hex digit: bit7 = a ... bit1 = g,
  // bit0 = dp. The outputs drive the bitwise inverse.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'h0:    pat = 8'hFC;
      4'h1:    pat = 8'h60;
      4'h2:    pat = 8'hDA;
      4'h3:    pat = 8'hF2;
      4'h4:    pat = 8'h66;
      4'h5:    pat = 8'hB6;
      4'h6:    pat = 8'hBE;
      4'h7:    pat = 8'hE0;
      4'h8:    pat = 8'hFE;
      4'h9:    pat = 8'hF6;
      4'hA:    pat = 8'hEE;
      4'hB:    pat = 8'h3E;
      4'hC:    pat = 8'h9C;
      4'hD:    pat = 8'h7A;
      4'hE:    pat = 8'h9E;
      default: pat = 8'h8E;
    endcase
    return pat;
  endfunction

  // Two-digit BCD increment, 99 rolls over to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val);
    logic [3:0] units;
    logic [3:0] tens;
    units = val[3:0];
    tens  = val[7:4];
    if (units == 4'd9) begin
      units = 4'd0;
      if (tens == 4'd9) begin
        tens = 4'd0;
      end else begin
        tens = tens + 4'd1;
      end
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

  // Next-state, pop strobe and key/counter bookkeeping.
  always_comb begin
    state_nx      = state;
    byte_nx       = byte_r;
    brk_nx        = brk;
    key_down_nx   = key_down;
    cur_code_nx   = cur_code;
    press_cnt_nx  = press_cnt;
    nextdata_n_nx = 1'b1;
    case (state)
      WAIT: begin
        if (ready) begin
          byte_nx       = data;
          state_nx      = POP;
          // Registered strobe: low exactly while the FSM sits in POP.
          nextdata_n_nx = 1'b0;
        end
      end
      POP: begin
        state_nx = PROC;
      end
      PROC: begin
        state_nx = WAIT;
        if (byte_r == CODE_EXT) begin
          // Extended prefix carries no information for the display.
          brk_nx = brk;
        end else if (byte_r == CODE_BRK) begin
          brk_nx = 1'b1;
        end else if (brk) begin
          brk_nx = 1'b0;
          // Only the release of the tracked key clears it.
          if (key_down && (byte_r == cur_code)) begin
            key_down_nx = 1'b0;
          end
        end else if (!(key_down && (byte_r == cur_code))) begin
          // New press (typematic repeat of the held key falls through).
          cur_code_nx  = byte_r;
          key_down_nx  = 1'b1;
          press_cnt_nx = bcd_inc(press_cnt);
        end
      end
      default: begin
        state_nx = WAIT;
      end
    endcase
  end

  // FSM and bookkeeping registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= WAIT;
      byte_r     <= 8'h00;
      brk        <= 1'b0;
      key_down   <= 1'b0;
      cur_code   <= 8'h00;
      press_cnt  <= 8'h00;
      nextdata_n <= 1'b1;
    end else begin
      state      <= state_nx;
      byte_r     <= byte_nx;
      brk        <= brk_nx;
      key_down   <= key_down_nx;
      cur_code   <= cur_code_nx;
      press_cnt  <= press_cnt_nx;
      nextdata_n <= nextdata_n_nx;
    end
  end

  // Segment registers, one cycle behind the key/counter state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      seg0 <= 8'hFF;
      seg1 <= 8'hFF;
      seg2 <= 8'h03;
      seg3 <= 8'h03;
    end else begin
      seg0 <= key_down ? ~hex_seg(cur_code[3:0]) : 8'hFF;
      seg1 <= key_down ? ~hex_seg(cur_code[7:4]) : 8'hFF;
      seg2 <= ~hex_seg(press_cnt[3:0]);
      seg3 <= ~hex_seg(press_cnt[7:4]);
    end
  end

endmodule
